// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit-side buffer.
// Launch FSM encoding and default data width.
package uart_pkg;

    localparam int DEF_DATA_WIDTH = 8;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_LAUNCH    = 2'd1;
    localparam logic [1:0] ST_WAIT_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE      = ST_IDLE,
        LAUNCH    = ST_LAUNCH,
        WAIT_DONE = ST_WAIT_DONE
    } tx_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock circular FIFO with explicit occupancy count.
// Head entry is presented combinationally on o_data.
import uart_pkg::*;

module uart_sync_fifo #(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int FIFO_DEPTH = 16,
    localparam int ADDR_WIDTH = $clog2(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_pop,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic [ADDR_WIDTH:0]   o_count,
    output logic                  o_full,
    output logic                  o_empty
);

    localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH+1)'(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic                  w_push;
    logic                  w_pop;

    assign o_full  = (r_count == FULL_CNT);
    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Count is kept separately so full and empty never alias.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + (ADDR_WIDTH+1)'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - (ADDR_WIDTH+1)'(1);
            end
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit buffer feeding a UART: FIFO, launch FSM, overflow flag.
// tx_data is held for the whole frame since the UART samples it throughout.
import uart_pkg::*;

module uart_tx_fifo #(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int FIFO_DEPTH = 16,
    localparam int ADDR_WIDTH = $clog2(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_valid,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_ready,
    output logic                  tx_enable,
    output logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_busy,
    output logic [ADDR_WIDTH:0]   fifo_count,
    output logic                  fifo_empty,
    output logic                  fifo_full,
    output logic                  overflow,
    input  logic                  overflow_clr
);

    tx_state_e             r_state;
    logic                  r_tx_enable;
    logic [DATA_WIDTH-1:0] r_tx_data;
    logic                  r_overflow;
    logic                  w_push;
    logic                  w_pop;
    logic [DATA_WIDTH-1:0] w_head;
    logic [ADDR_WIDTH:0]   w_count;
    logic                  w_full;
    logic                  w_empty;

    assign w_push = wr_valid && !w_full;
    assign w_pop  = (r_state == IDLE) && !w_empty && !tx_busy;

    uart_sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  (wr_data),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign wr_ready   = !w_full;
    assign fifo_full  = w_full;
    assign fifo_empty = w_empty;
    assign fifo_count = w_count;
    assign tx_enable  = r_tx_enable;
    assign tx_data    = r_tx_data;
    assign overflow   = r_overflow;

    // Enable is held in LAUNCH until the UART reports busy on its baud tick.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_tx_enable <= 1'b0;
            r_tx_data   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_tx_enable <= 1'b0;
                    if (w_pop) begin
                        r_tx_data <= w_head;
                        r_state   <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    if (tx_busy) begin
                        r_tx_enable <= 1'b0;
                        r_state     <= WAIT_DONE;
                    end else begin
                        r_tx_enable <= 1'b1;
                    end
                end
                WAIT_DONE: begin
                    r_tx_enable <= 1'b0;
                    if (!tx_busy) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_tx_enable <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_overflow <= 1'b0;
        end else if (wr_valid && w_full) begin
            r_overflow <= 1'b1;
        end else if (overflow_clr) begin
            r_overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a simple UART busy model.
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       wr_valid = 1'b0;
    logic [7:0] wr_data = '0;
    logic       wr_ready;
    logic       tx_enable;
    logic [7:0] tx_data;
    logic       tx_busy;
    logic [4:0] fifo_count;
    logic       fifo_empty;
    logic       fifo_full;
    logic       overflow;
    logic       overflow_clr = 1'b0;

    int n_chk = 0;
    int n_pass = 0;

    logic       m_busy;
    logic       m_armed;
    logic [7:0] m_data;
    int         m_cnt;
    logic       busy_force = 1'b0;
    logic       rand_len = 1'b0;
    int         frame_len = 5;
    int         stab_err = 0;
    int         en_err = 0;
    logic       prev_eb = 1'b0;
    logic [7:0] launched[$];

    assign tx_busy = m_busy | busy_force;

    uart_tx_fifo dut (
        .clk          (clk),
        .reset        (reset),
        .wr_valid     (wr_valid),
        .wr_data      (wr_data),
        .wr_ready     (wr_ready),
        .tx_enable    (tx_enable),
        .tx_data      (tx_data),
        .tx_busy      (tx_busy),
        .fifo_count   (fifo_count),
        .fifo_empty   (fifo_empty),
        .fifo_full    (fifo_full),
        .overflow     (overflow),
        .overflow_clr (overflow_clr)
    );

    always #5 clk = ~clk;

    // UART model: starts one baud tick after enable, busy for a frame.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_busy  <= 1'b0;
            m_armed <= 1'b0;
            m_cnt   <= 0;
        end else if (!m_busy) begin
            if (tx_enable && !busy_force) begin
                if (m_armed) begin
                    m_busy  <= 1'b1;
                    m_data  <= tx_data;
                    m_cnt   <= rand_len ? int'($urandom_range(1, 8)) : frame_len;
                    m_armed <= 1'b0;
                    launched.push_back(tx_data);
                end else begin
                    m_armed <= 1'b1;
                end
            end else begin
                m_armed <= 1'b0;
            end
        end else begin
            if (tx_data != m_data) stab_err <= stab_err + 1;
            if (m_cnt <= 1) m_busy <= 1'b0;
            else m_cnt <= m_cnt - 1;
        end
    end

    always @(negedge clk) begin
        if (tx_enable && tx_busy && prev_eb) en_err <= en_err + 1;
        prev_eb <= tx_enable && tx_busy;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [31:0] lau(input int i);
        return (launched.size() > i) ? 32'(launched[i]) : 32'hDEAD;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        wr_valid = 1'b0;
        overflow_clr = 1'b0;
        busy_force = 1'b0;
        rand_len = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        launched.delete();
    endtask

    task automatic push(input logic [7:0] d);
        wr_data = d;
        wr_valid = 1'b1;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic wait_launches(input int n, input string tag);
        int k = 0;
        while ((launched.size() < n || tx_busy || !fifo_empty
                || tx_enable) && k < 3000) begin
            tick();
            k++;
        end
        tick();
        tick();
        chk({tag, "_tmo"}, 32'(k < 3000), 1);
    endtask

    initial begin
        int k;
        logic [7:0] exp_b;
        #3;
        chk("rst_cnt", 32'(fifo_count), 0);
        chk("rst_empty", 32'(fifo_empty), 1);
        chk("rst_full", 32'(fifo_full), 0);
        chk("rst_ready", 32'(wr_ready), 1);
        chk("rst_en", 32'(tx_enable), 0);
        chk("rst_data", 32'(tx_data), 0);
        chk("rst_ovf", 32'(overflow), 0);

        do_reset();
        frame_len = 5;
        push(8'hA5);
        chk("t1_cnt1", 32'(fifo_count), 1);
        tick();
        chk("t1_en_n1", 32'(tx_enable), 0);
        chk("t1_data", 32'(tx_data), 32'hA5);
        chk("t1_cnt0", 32'(fifo_count), 0);
        tick();
        chk("t1_en_n2", 32'(tx_enable), 1);
        k = 0;
        while (!tx_busy && k < 20) begin
            tick();
            k++;
        end
        chk("t1_busy_tmo", 32'(k < 20), 1);
        chk("t1_en_hold", 32'(tx_enable), 1);
        tick();
        chk("t1_en_drop", 32'(tx_enable), 0);
        wait_launches(1, "t1");
        chk("t1_byte", lau(0), 32'hA5);
        chk("t1_cnt_end", 32'(fifo_count), 0);

        launched.delete();
        frame_len = 20;
        for (int i = 1; i <= 4; i++) push(8'(i));
        wait_launches(4, "t2");
        chk("t2_num", 32'(launched.size()), 4);
        for (int i = 0; i < 4; i++) chk("t2_order", lau(i), 32'(i + 1));

        do_reset();
        busy_force = 1'b1;
        for (int i = 0; i < 16; i++) push(8'h10 + 8'(i));
        chk("t3_cnt16", 32'(fifo_count), 16);
        chk("t3_full", 32'(fifo_full), 1);
        chk("t3_ready", 32'(wr_ready), 0);
        chk("t3_ovf0", 32'(overflow), 0);
        push(8'hFF);
        chk("t3_ovf_set", 32'(overflow), 1);
        chk("t3_cnt_kept", 32'(fifo_count), 16);
        overflow_clr = 1'b1;
        tick();
        overflow_clr = 1'b0;
        chk("t3_ovf_clr", 32'(overflow), 0);
        overflow_clr = 1'b1;
        wr_data = 8'hFE;
        wr_valid = 1'b1;
        tick();
        overflow_clr = 1'b0;
        wr_valid = 1'b0;
        chk("t3_set_wins", 32'(overflow), 1);
        frame_len = 2;
        busy_force = 1'b0;
        wait_launches(16, "t3");
        chk("t3_num", 32'(launched.size()), 16);
        chk("t3_first", lau(0), 32'h10);
        chk("t3_last", lau(15), 32'h1F);
        chk("t3_ovf_sticky", 32'(overflow), 1);

        do_reset();
        busy_force = 1'b1;
        push(8'h31);
        push(8'h32);
        push(8'h33);
        chk("t4_cnt_pre", 32'(fifo_count), 3);
        busy_force = 1'b0;
        wr_data = 8'h34;
        wr_valid = 1'b1;
        tick();
        wr_valid = 1'b0;
        chk("t4_cnt_same", 32'(fifo_count), 3);
        chk("t4_pop_old", 32'(tx_data), 32'h31);
        wait_launches(4, "t4");
        for (int i = 0; i < 4; i++) chk("t4_order", lau(i), 32'h31 + 32'(i));

        do_reset();
        rand_len = 1'b1;
        for (int i = 0; i < 40; i++) begin
            k = 0;
            while (!wr_ready && k < 500) begin
                tick();
                k++;
            end
            if (k >= 500) chk("t5_ready_tmo", 0, 1);
            push(8'(i * 7 + 3));
        end
        wait_launches(40, "t5");
        chk("t5_num", 32'(launched.size()), 40);
        for (int i = 0; i < 40; i++) begin
            exp_b = 8'(i * 7 + 3);
            chk("t5_order", lau(i), 32'(exp_b));
        end

        do_reset();
        frame_len = 30;
        for (int i = 0; i < 6; i++) push(8'h50 + 8'(i));
        k = 0;
        while (!(tx_busy && !tx_enable) && k < 50) begin
            tick();
            k++;
        end
        chk("t6_wait_tmo", 32'(k < 50), 1);
        chk("t6_cnt5", 32'(fifo_count), 5);
        chk("t6_data", 32'(tx_data), 32'h50);
        #2;
        reset = 1'b0;
        #1;
        chk("t6_async_en", 32'(tx_enable), 0);
        chk("t6_async_cnt", 32'(fifo_count), 0);
        chk("t6_async_data", 32'(tx_data), 0);
        chk("t6_async_empty", 32'(fifo_empty), 1);
        tick();
        reset = 1'b1;
        launched.delete();
        frame_len = 3;
        for (int i = 0; i < 10; i++) tick();
        chk("t6_no_launch", 32'(launched.size()), 0);
        chk("t6_en_idle", 32'(tx_enable), 0);
        push(8'h77);
        wait_launches(1, "t6");
        chk("t6_new_byte", lau(0), 32'h77);

        chk("stable_data", 32'(stab_err), 0);
        chk("no_en_busy", 32'(en_err), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
